fetch_pc_seq: RTL and testbench

FETCH_PC_SEQ -- requirements
Module: fetch_pc_seq

---
 rtl/fetch_pc_seq_if.sv | 26 ++
 rtl/fetch_pc_seq.sv | 75 +++++++
 tb/tb_fetch_pc_seq.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_seq_if.sv
// Fetch PC sequencer bus: backend redirect, branch-select feedback and fetch-group outputs.
// Signal names match the legacy port list so the instantiating fetch stage needs no renaming.
interface fetch_pc_seq_if;
  logic        flush_i;
  logic [31:0] flushDest_i;
  logic        ifReady_i;
  logic        validTake_i;
  logic [31:0] validDest_i;
  logic        needDelaySlot_i;

  logic        fetchReq_o;
  logic [31:0] fetchPC_o;
  logic [31:0] fifthPC_o;
  logic [3:0]  originEnable_o;
  logic        dsPending_o;

  modport slave (
    input  flush_i, flushDest_i, ifReady_i, validTake_i, validDest_i, needDelaySlot_i,
    output fetchReq_o, fetchPC_o, fifthPC_o, originEnable_o, dsPending_o
  );

  modport master (
    output flush_i, flushDest_i, ifReady_i, validTake_i, validDest_i, needDelaySlot_i,
    input  fetchReq_o, fetchPC_o, fifthPC_o, originEnable_o, dsPending_o
  );
endinterface

// File: rtl/fetch_pc_seq.sv
// Fetch PC sequencer: steps 16-byte fetch groups, follows predicted branches and
// inserts a delay-slot-only group when the taken branch sits in the last slot.
module fetch_pc_seq (
  input logic           clk,
  input logic           rst,
  fetch_pc_seq_if.slave bus
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] WAIT_DS = 1'b1;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic [0:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] saved_dest;
  logic        fetch_req;
  logic        accept;
  logic        take_with_ds;
  logic [31:0] fifth_pc;
  logic [3:0]  origin_enable;

  assign accept       = fetch_req & bus.ifReady_i;
  assign take_with_ds = bus.validTake_i & bus.needDelaySlot_i;
  assign fifth_pc     = {fetch_pc[31:4] + 28'd1, 4'b0000};

  always_comb begin
    origin_enable = 4'b1111;
    if (state == WAIT_DS) begin
      origin_enable = 4'b0001;
    end else begin
      unique case (fetch_pc[3:2])
        2'b00:   origin_enable = 4'b1111;
        2'b01:   origin_enable = 4'b1110;
        2'b10:   origin_enable = 4'b1100;
        default: origin_enable = 4'b1000;
      endcase
    end
  end

  // Flush outranks any coincident accept; the saved branch target is dropped with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      fetch_pc   <= RESET_PC;
      saved_dest <= '0;
      fetch_req  <= 1'b0;
    end else begin
      fetch_req <= 1'b1;
      if (bus.flush_i) begin
        fetch_pc   <= bus.flushDest_i;
        saved_dest <= '0;
        state      <= RUN;
      end else if (accept) begin
        if (state == WAIT_DS) begin
          fetch_pc <= saved_dest;
          state    <= RUN;
        end else if (take_with_ds) begin
          fetch_pc   <= fifth_pc;
          saved_dest <= bus.validDest_i;
          state      <= WAIT_DS;
        end else begin
          fetch_pc <= bus.validDest_i;
        end
      end
    end
  end

  assign bus.fetchReq_o     = fetch_req;
  assign bus.fetchPC_o      = fetch_pc;
  assign bus.fifthPC_o      = fifth_pc;
  assign bus.originEnable_o = origin_enable;
  assign bus.dsPending_o    = (state == WAIT_DS);

endmodule

// File: tb/tb_fetch_pc_seq.sv
// Self-checking bench for fetch_pc_seq: directed scenarios plus randomized traffic
// against a behavioural model of the fetch-PC rules.
module tb_fetch_pc_seq;

  logic clk;
  logic rst;
  fetch_pc_seq_if bus ();

  fetch_pc_seq dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_saved;
  logic        m_ds;
  logic        m_req;

  function automatic logic [31:0] m_fifth();
    return (m_pc & 32'hFFFF_FFF0) + 32'd16;
  endfunction

  function automatic logic [3:0] m_en();
    logic [3:0] full;
    full = 4'b1111;
    if (m_ds) return 4'b0001;
    return full << m_pc[3:2];
  endfunction

  task automatic drive(input logic fl, input logic [31:0] fd, input logic rdy,
                       input logic tk, input logic [31:0] vd, input logic nds);
    bus.flush_i         = fl;
    bus.flushDest_i     = fd;
    bus.ifReady_i       = rdy;
    bus.validTake_i     = tk;
    bus.validDest_i     = vd;
    bus.needDelaySlot_i = nds;
  endtask

  task automatic model_reset();
    m_pc    = 32'hBFC0_0000;
    m_saved = '0;
    m_ds    = 1'b0;
    m_req   = 1'b0;
  endtask

  // advance one clock edge, updating the model from the inputs currently driven
  task automatic tick();
    logic [31:0] nxt_pc;
    logic [31:0] nxt_saved;
    logic        nxt_ds;
    nxt_pc    = m_pc;
    nxt_saved = m_saved;
    nxt_ds    = m_ds;
    if (bus.flush_i) begin
      nxt_pc    = bus.flushDest_i;
      nxt_saved = '0;
      nxt_ds    = 1'b0;
    end else if (m_req && bus.ifReady_i) begin
      if (m_ds) begin
        nxt_pc = m_saved;
        nxt_ds = 1'b0;
      end else if (bus.validTake_i && bus.needDelaySlot_i) begin
        nxt_saved = bus.validDest_i;
        nxt_pc    = m_fifth();
        nxt_ds    = 1'b1;
      end else begin
        nxt_pc = bus.validDest_i;
      end
    end
    @(posedge clk);
    #1;
    m_pc    = nxt_pc;
    m_saved = nxt_saved;
    m_ds    = nxt_ds;
    m_req   = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] dest);
    drive(1'b1, dest, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.fetchReq_o, bus.dsPending_o, bus.fetchPC_o} !== {1'b0, 1'b0, 32'hBFC0_0000}) begin
      n_fail++;
      $display("FAIL reset_state: req/ds/pc got %b/%b/%h want 0/0/bfc00000",
               bus.fetchReq_o, bus.dsPending_o, bus.fetchPC_o);
    end
    n_cmp++;
    if (bus.originEnable_o !== 4'b1111 || bus.fifthPC_o !== 32'hBFC0_0010) begin
      n_fail++;
      $display("FAIL reset_enable: en=%b fifth=%h want 1111/bfc00010", bus.originEnable_o, bus.fifthPC_o);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.fetchReq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL release_req_low: got %b want 0", bus.fetchReq_o);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h1234_5670, 1'b0);
    tick();
    n_cmp++;
    if (bus.fetchReq_o !== 1'b1 || bus.fetchPC_o !== 32'hBFC0_0000) begin
      n_fail++;
      $display("FAIL first_edge: req=%b pc=%h want 1/bfc00000", bus.fetchReq_o, bus.fetchPC_o);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hBFC0_0000;
    exp_pc[1] = 32'hBFC0_0010;
    exp_pc[2] = 32'hBFC0_0020;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.fetchPC_o !== exp_pc[i] || bus.originEnable_o !== 4'b1111 || bus.fetchReq_o !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_%0d: pc=%h en=%b req=%b want %h/1111/1", i,
                 bus.fetchPC_o, bus.originEnable_o, bus.fetchReq_o, exp_pc[i]);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0, exp_pc[i] + 32'd16, 1'b0);
      tick();
    end
  endtask

  task automatic test_take_no_ds();
    redirect(32'hBFC0_0008);
    n_cmp++;
    if (bus.fetchPC_o !== 32'hBFC0_0008 || bus.originEnable_o !== 4'b1100) begin
      n_fail++;
      $display("FAIL take_pre: pc=%h en=%b want bfc00008/1100", bus.fetchPC_o, bus.originEnable_o);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_1234, 1'b0);
    tick();
    n_cmp++;
    if (bus.fetchPC_o !== 32'h8000_1234 || bus.originEnable_o !== 4'b1110 || bus.dsPending_o !== 1'b0) begin
      n_fail++;
      $display("FAIL take_post: pc=%h en=%b ds=%b want 80001234/1110/0",
               bus.fetchPC_o, bus.originEnable_o, bus.dsPending_o);
    end
  endtask

  task automatic test_delay_slot();
    redirect(32'hBFC0_0000);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0040, 1'b1);
    tick();
    n_cmp++;
    if (bus.fetchPC_o !== 32'hBFC0_0010 || bus.dsPending_o !== 1'b1 || bus.originEnable_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL ds_enter: pc=%h ds=%b en=%b want bfc00010/1/0001",
               bus.fetchPC_o, bus.dsPending_o, bus.originEnable_o);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h1234_5678, 1'b1);
    tick();
    n_cmp++;
    if (bus.fetchPC_o !== 32'h8000_0040 || bus.dsPending_o !== 1'b0 || bus.originEnable_o !== 4'b1111) begin
      n_fail++;
      $display("FAIL ds_exit: pc=%h ds=%b en=%b want 80000040/0/1111",
               bus.fetchPC_o, bus.dsPending_o, bus.originEnable_o);
    end
  endtask

  task automatic test_stall_flush();
    redirect(32'hBFC0_0000);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0040, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      tick();
      n_cmp++;
      if (bus.fetchPC_o !== 32'hBFC0_0010 || bus.dsPending_o !== 1'b1 || bus.originEnable_o !== 4'b0001) begin
        n_fail++;
        $display("FAIL stall_%0d: pc=%h ds=%b en=%b want bfc00010/1/0001", i,
                 bus.fetchPC_o, bus.dsPending_o, bus.originEnable_o);
      end
    end
    drive(1'b1, 32'hBFC0_0380, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    n_cmp++;
    if (bus.fetchPC_o !== 32'hBFC0_0380 || bus.dsPending_o !== 1'b0 || bus.originEnable_o !== 4'b1111) begin
      n_fail++;
      $display("FAIL stall_flush: pc=%h ds=%b en=%b want bfc00380/0/1111",
               bus.fetchPC_o, bus.dsPending_o, bus.originEnable_o);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'hBFC0_0390, 1'b0);
    tick();
    n_cmp++;
    if (bus.fetchPC_o !== 32'hBFC0_0390) begin
      n_fail++;
      $display("FAIL saved_dropped: pc=%h want bfc00390", bus.fetchPC_o);
    end
  endtask

  task automatic test_wrap_misaligned();
    redirect(32'hFFFF_FFF0);
    n_cmp++;
    if (bus.fetchPC_o !== 32'hFFFF_FFF0 || bus.fifthPC_o !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL wrap: pc=%h fifth=%h want fffffff0/00000000", bus.fetchPC_o, bus.fifthPC_o);
    end
    redirect(32'hFFFF_FFFC);
    n_cmp++;
    if (bus.fifthPC_o !== 32'h0000_0000 || bus.originEnable_o !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_slot3: fifth=%h en=%b want 00000000/1000", bus.fifthPC_o, bus.originEnable_o);
    end
    redirect(32'hBFC0_0006);
    n_cmp++;
    if (bus.fetchPC_o !== 32'hBFC0_0006 || bus.originEnable_o !== 4'b1110 || bus.fifthPC_o !== 32'hBFC0_0010) begin
      n_fail++;
      $display("FAIL misaligned: pc=%h en=%b fifth=%h want bfc00006/1110/bfc00010",
               bus.fetchPC_o, bus.originEnable_o, bus.fifthPC_o);
    end
  endtask

  task automatic test_flush_priority();
    redirect(32'hBFC0_0000);
    drive(1'b1, 32'hBFC0_0380, 1'b1, 1'b1, 32'h8000_0040, 1'b1);
    tick();
    n_cmp++;
    if (bus.fetchPC_o !== 32'hBFC0_0380 || bus.dsPending_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_vs_take: pc=%h ds=%b want bfc00380/0", bus.fetchPC_o, bus.dsPending_o);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0040, 1'b1);
    tick();
    drive(1'b1, 32'hA000_0100, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    n_cmp++;
    if (bus.fetchPC_o !== 32'hA000_0100 || bus.dsPending_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_vs_ds_accept: pc=%h ds=%b want a0000100/0", bus.fetchPC_o, bus.dsPending_o);
    end
  endtask

  task automatic test_reset_mid_ds();
    redirect(32'hBFC0_0000);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0040, 1'b1);
    tick();
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({bus.fetchReq_o, bus.dsPending_o, bus.fetchPC_o} !== {1'b0, 1'b0, 32'hBFC0_0000}) begin
      n_fail++;
      $display("FAIL async_reset: req/ds/pc got %b/%b/%h want 0/0/bfc00000",
               bus.fetchReq_o, bus.dsPending_o, bus.fetchPC_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'hBFC0_0010, 1'b0);
    tick();
    tick();
    n_cmp++;
    if (bus.fetchPC_o !== 32'hBFC0_0010 || bus.dsPending_o !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_ds: pc=%h ds=%b want bfc00010/0", bus.fetchPC_o, bus.dsPending_o);
    end
  endtask

  task automatic test_random();
    logic [69:0] got;
    logic [69:0] exp;
    int          bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) == 0));
      if (bus.validTake_i == 1'b0) bus.validDest_i = m_fifth();
      tick();
      got = {bus.fetchReq_o, bus.dsPending_o, bus.fetchPC_o, bus.fifthPC_o, bus.originEnable_o};
      exp = {m_req, m_ds, m_pc, m_fifth(), m_en()};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_%0d: req/ds/pc/fifth/en got %b/%b/%h/%h/%b want %b/%b/%h/%h/%b", i,
                   got[69], got[68], got[67:36], got[35:4], got[3:0],
                   exp[69], exp[68], exp[67:36], exp[35:4], exp[3:0]);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_sequential();
    test_take_no_ds();
    test_delay_slot();
    test_stall_flush();
    test_wrap_misaligned();
    test_flush_priority();
    test_reset_mid_ds();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
